// File: rtl/hbmc_ufifo_rd_sched.sv
// Read-side scheduler for the upstream data FIFO: credit-gated read command issue and AXI-R style drain.
// Optional HBMC_UFIFO_LAST_CHECK_EN flags beats whose FIFO last flag disagrees with the descriptor count.
module hbmc_ufifo_rd_sched #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_len,
  input  logic [ID_WIDTH-1:0]   req_id,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [10:0]           cmd_words,
  input  logic [DATA_WIDTH-1:0] fifo_rd_dout,
  input  logic                  fifo_rd_last,
  input  logic                  fifo_rd_empty,
  output logic                  fifo_rd_ena,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic                  r_last,
  output logic                  r_err,
  output logic                  busy
);
  localparam int unsigned CRED_W = 10;
  localparam int unsigned PTR_W  = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WPB    = DATA_WIDTH / 16;

  typedef struct packed {
    logic [7:0]          len;
    logic [ID_WIDTH-1:0] id;
  } desc_t;

  typedef enum logic {S_IDLE, S_CMD} state_t;

  state_t            state, state_nxt;
  logic [CRED_W-1:0] credit;
  logic [CRED_W-1:0] len_p1;
  desc_t             q_mem [MAX_OUTST];
  desc_t             head;
  logic [PTR_W-1:0]  q_wr, q_rd;
  logic [CNT_W-1:0]  q_cnt;
  logic [7:0]        beat;
  logic              q_empty, q_full, credit_ok, accept, hs, pop;

  assign len_p1    = CRED_W'(req_len) + CRED_W'(1);
  assign credit_ok = credit >= len_p1;
  assign q_empty   = (q_cnt == '0);
  assign q_full    = (q_cnt == CNT_W'(MAX_OUTST));
  assign head      = q_mem[q_rd];
  assign accept    = req_valid && req_ready;

  // Request FSM: one command per accepted burst, space already reserved in credit.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    cmd_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = !rst && credit_ok && !q_full;
        if (req_valid && req_ready) state_nxt = S_CMD;
      end
      S_CMD: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_words <= '0;
      credit    <= CRED_W'(FIFO_DEPTH);
    end else begin
      if (accept) cmd_words <= 11'((32'(req_len) + 32'd1) * WPB);
      credit <= credit + CRED_W'(hs) - (accept ? len_p1 : CRED_W'(0));
    end
  end

  // Descriptor queue; a new entry becomes the head one cycle after its push at the earliest.
  always_ff @(posedge clk) begin
    if (accept) q_mem[q_wr] <= {req_len, req_id};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_wr  <= '0;
      q_rd  <= '0;
      q_cnt <= '0;
      beat  <= '0;
    end else begin
      if (accept) q_wr <= q_wr + PTR_W'(1);
      if (pop)    q_rd <= q_rd + PTR_W'(1);
      q_cnt <= q_cnt + CNT_W'(accept) - CNT_W'(pop);
      if (hs) beat <= r_last ? 8'd0 : beat + 8'd1;
    end
  end

  assign r_valid     = !rst && !q_empty && !fifo_rd_empty;
  assign hs          = r_valid && r_ready;
  assign fifo_rd_ena = hs;
  assign r_data      = fifo_rd_dout;
  assign r_id        = head.id;
  assign r_last      = !q_empty && (beat == head.len);
  assign pop         = hs && r_last;
  assign busy        = (state != S_IDLE) || !q_empty;

`ifdef HBMC_UFIFO_LAST_CHECK_EN
  logic err_q, mism;

  // Beat count stays authoritative; the flag only raises a sticky error.
  assign mism  = hs && (fifo_rd_last != r_last);
  assign r_err = err_q || mism;

  always_ff @(posedge clk) begin
    if (rst)       err_q <= 1'b0;
    else if (mism) err_q <= 1'b1;
  end
`else
  logic unused_last;

  assign unused_last = fifo_rd_last;
  assign r_err       = 1'b0;
`endif

endmodule

// File: tb/tb_hbmc_ufifo_rd_sched.sv
// Self-checking bench for hbmc_ufifo_rd_sched: directed scenarios plus randomized traffic against
// a transaction-level model (credit integer, descriptor queue, bench-owned FWFT FIFO).
module tb_hbmc_ufifo_rd_sched;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned MAXO  = 4;
  localparam int unsigned IDW   = 4;
`ifdef HBMC_UFIFO_LAST_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0, req_ready;
  logic [7:0]     req_len = '0;
  logic [IDW-1:0] req_id = '0;
  logic           cmd_valid, cmd_ready = 1'b1;
  logic [10:0]    cmd_words;
  logic [DW-1:0]  fifo_rd_dout;
  logic           fifo_rd_last, fifo_rd_empty, fifo_rd_ena;
  logic           r_valid, r_ready = 1'b0;
  logic [DW-1:0]  r_data;
  logic [IDW-1:0] r_id;
  logic           r_last, r_err, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hbmc_ufifo_rd_sched #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_OUTST(MAXO), .ID_WIDTH(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len), .req_id(req_id),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_words(cmd_words),
    .fifo_rd_dout(fifo_rd_dout), .fifo_rd_last(fifo_rd_last), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_ena(fifo_rd_ena),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id), .r_last(r_last),
    .r_err(r_err), .busy(busy)
  );

  // Bench-owned FWFT FIFO standing in for the memory return path
  logic [DW-1:0] f_data [0:1023];
  logic          f_last [0:1023];
  logic [10:0]   f_wr = '0, f_rd = '0;
  assign fifo_rd_empty = (f_wr == f_rd);
  assign fifo_rd_dout  = f_data[f_rd[9:0]];
  assign fifo_rd_last  = f_last[f_rd[9:0]];

  // Reference model state
  typedef struct { int len; int id; } desc_t;
  desc_t m_q[$];
  int    owed_q[$];
  int    m_credit, m_beat, m_words;
  bit    m_cmd, m_err;

  function automatic void m_reset();
    m_q.delete(); owed_q.delete();
    m_credit = DEPTH; m_beat = 0; m_words = 0; m_cmd = 0; m_err = 0;
  endfunction

  function automatic bit exp_req_ready();
    return !rst && !m_cmd && (m_credit >= int'(req_len) + 1) && (m_q.size() < int'(MAXO));
  endfunction

  function automatic bit exp_r_valid();
    return !rst && (m_q.size() != 0) && (f_wr != f_rd);
  endfunction

  function automatic bit exp_r_last();
    return (m_q.size() != 0) && (m_beat == m_q[0].len);
  endfunction

  function automatic bit exp_r_err();
    return LC && (m_err || (exp_r_valid() && r_ready && (f_last[f_rd[9:0]] != exp_r_last())));
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (rst) begin
        m_reset();
        f_rd <= f_wr;
      end else begin
        bit    acc, hs;
        desc_t d;
        acc = exp_req_ready() && req_valid;
        hs  = exp_r_valid() && r_ready;
        if (hs) begin
          if (LC && (f_last[f_rd[9:0]] != exp_r_last())) m_err = 1;
          m_credit++;
          f_rd <= f_rd + 11'd1;
          if (m_beat == m_q[0].len) begin void'(m_q.pop_front()); m_beat = 0; end
          else m_beat++;
        end
        if (m_cmd && cmd_ready) m_cmd = 0;
        if (acc) begin
          d.len = int'(req_len); d.id = int'(req_id);
          m_q.push_back(d);
          owed_q.push_back(d.len + 1);
          m_credit -= d.len + 1;
          m_cmd = 1;
          m_words = (d.len + 1) * int'(DW) / 16;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Push words owed to accepted bursts; last flag follows burst boundaries, word index bad also forced high
  task automatic push_words(input int n, input int bad);
    for (int k = 0; k < n; k++) begin
      if (owed_q.size() == 0) break;
      f_data[f_wr[9:0]] = DW'($urandom);
      f_last[f_wr[9:0]] = (owed_q[0] == 1) || (k == bad);
      owed_q[0] = owed_q[0] - 1;
      if (owed_q[0] == 0) void'(owed_q.pop_front());
      f_wr = f_wr + 11'd1;
    end
  endtask

  task automatic issue(input int len, input int id);
    bit ok = 0;
    req_valid = 1; req_len = 8'(len); req_id = IDW'(id); cmd_ready = 1;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (exp_req_ready()) begin
        ok = (req_ready === 1'b1);
        tick();
        break;
      end
      tick();
    end
    req_valid = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL issue_accept: len=%0d id=%0d got req_ready=%b want 1", len, id, req_ready); end
  endtask

  task automatic flush();
    bit done = 0;
    req_valid = 0; cmd_ready = 1; r_ready = 1;
    for (int c = 0; c < 3000; c++) begin
      push_words(1024, -1);
      #1;
      if (m_q.size() == 0 && !m_cmd) begin done = 1; break; end
      tick();
    end
    r_ready = 0;
    checks++;
    if (!done || busy !== 1'b0) begin errors++; $display("FAIL flush_drain: got busy=%b done=%0d want busy=0 done=1", busy, done); end
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 0; r_ready = 0; cmd_ready = 1;
    tick(); tick(); #1;
    checks++;
    if ({req_ready, cmd_valid, r_valid, fifo_rd_ena, r_last, r_err, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000000", {req_ready, cmd_valid, r_valid, fifo_rd_ena, r_last, r_err, busy});
    end
    rst = 0; req_len = 0; #1;
    checks++;
    if (req_ready !== 1'b1 || dut.credit !== 10'(DEPTH)) begin
      errors++; $display("FAIL reset_credit: got req_ready=%b credit=%0d want 1 %0d", req_ready, dut.credit, DEPTH);
    end
    tick();
  endtask

  task automatic test_single_burst();
    req_valid = 1; req_len = 7; req_id = 3; cmd_ready = 1; #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL single_req_ready: got %b want 1", req_ready); end
    tick(); req_valid = 0; #1;
    checks++;
    if (cmd_valid !== 1'b1 || cmd_words !== 11'd16 || busy !== 1'b1) begin
      errors++; $display("FAIL single_cmd: got valid=%b words=%0d busy=%b want 1 16 1", cmd_valid, cmd_words, busy);
    end
    tick(); #1;
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL single_cmd_done: got %b want 0", cmd_valid); end
    push_words(8, -1); r_ready = 1; #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r_valid !== 1'b1 || fifo_rd_ena !== 1'b1 || r_id !== 4'd3 || r_last !== (i == 7) || r_data !== f_data[f_rd[9:0]]) begin
        errors++;
        $display("FAIL single_beat%0d: got v=%b ena=%b id=%0d last=%b data=%h want 1 1 3 %0d %h",
                 i, r_valid, fifo_rd_ena, r_id, r_last, r_data, (i == 7), f_data[f_rd[9:0]]);
      end
      tick(); #1;
    end
    r_ready = 0;
    checks++;
    if (busy !== 1'b0 || r_valid !== 1'b0 || dut.credit !== 10'(DEPTH)) begin
      errors++; $display("FAIL single_end: got busy=%b v=%b credit=%0d want 0 0 %0d", busy, r_valid, dut.credit, DEPTH);
    end
  endtask

  task automatic test_credit_stall();
    bit seen = 0;
    r_ready = 0;
    issue(255, 1); issue(255, 2); tick(); #1;
    checks++;
    if (dut.credit !== 10'd0) begin errors++; $display("FAIL stall_credit0: got %0d want 0", dut.credit); end
    req_valid = 1; req_len = 0; req_id = 3;
    for (int c = 0; c < 6; c++) begin #1; if (req_ready !== 1'b0) seen = 1; tick(); end
    checks++;
    if (seen) begin errors++; $display("FAIL stall_no_ready: got req_ready=1 want 0"); end
    push_words(1, -1); r_ready = 1; #1;
    checks++;
    if (fifo_rd_ena !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL stall_pop: got ena=%b req_ready=%b want 1 0", fifo_rd_ena, req_ready);
    end
    tick(); r_ready = 0; #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", req_ready); end
    tick(); req_valid = 0;
    flush();
  endtask

  task automatic test_queue_full();
    for (int i = 0; i < 4; i++) issue(0, 4 + i);
    tick();
    req_valid = 1; req_len = 0; req_id = 8; #1;
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL qfull_block: got req_ready=%b busy=%b want 0 1", req_ready, busy); end
    push_words(1, -1); r_ready = 1; #1;
    checks++;
    if (fifo_rd_ena !== 1'b1 || r_last !== 1'b1 || r_id !== 4'd4) begin
      errors++; $display("FAIL qfull_drain: got ena=%b last=%b id=%0d want 1 1 4", fifo_rd_ena, r_last, r_id);
    end
    tick(); r_ready = 0; #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL qfull_release: got %b want 1", req_ready); end
    tick(); req_valid = 0;
    flush();
  endtask

  task automatic test_backpressure();
    int beats = 0;
    issue(3, 5); push_words(4, -1);
    for (int c = 0; c < 20 && beats < 4; c++) begin
      r_ready = (c % 2 == 0); #1;
      checks++;
      if (r_valid !== 1'b1 || fifo_rd_ena !== r_ready) begin
        errors++; $display("FAIL bp_ena_c%0d: got v=%b ena=%b want 1 %b", c, r_valid, fifo_rd_ena, r_ready);
      end
      if (r_ready) begin
        checks++;
        if (r_last !== (beats == 3) || r_id !== 4'd5 || r_data !== f_data[f_rd[9:0]]) begin
          errors++; $display("FAIL bp_beat%0d: got last=%b id=%0d data=%h want %0d 5 %h", beats, r_last, r_id, r_data, (beats == 3), f_data[f_rd[9:0]]);
        end
        beats++;
      end
      tick();
    end
    r_ready = 0; #1;
    checks++;
    if (beats != 4 || busy !== 1'b0 || r_valid !== 1'b0) begin
      errors++; $display("FAIL bp_end: got beats=%0d busy=%b v=%b want 4 0 0", beats, busy, r_valid);
    end
  endtask

  task automatic test_simultaneous();
    issue(3, 2); push_words(4, -1); r_ready = 0; #1;
    checks++;
    if (dut.credit !== 10'd508) begin errors++; $display("FAIL sim_credit_pre: got %0d want 508", dut.credit); end
    tick();
    req_valid = 1; req_len = 15; req_id = 9; r_ready = 1; #1;
    checks++;
    if (req_ready !== 1'b1 || fifo_rd_ena !== 1'b1) begin
      errors++; $display("FAIL sim_both: got req_ready=%b ena=%b want 1 1", req_ready, fifo_rd_ena);
    end
    tick(); req_valid = 0; r_ready = 0; #1;
    checks++;
    if (dut.credit !== 10'd493) begin errors++; $display("FAIL sim_credit_post: got %0d want 493", dut.credit); end
    flush();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] e;
      req_valid = 1'($urandom_range(0, 1));
      req_len   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      req_id    = IDW'($urandom);
      cmd_ready = ($urandom_range(0, 3) != 0);
      r_ready   = ($urandom_range(0, 2) != 0);
      if (owed_q.size() != 0 && $urandom_range(0, 1) == 1) push_words(int'($urandom_range(1, 4)), -1);
      #1;
      e = {exp_req_ready(), m_cmd, exp_r_valid(), exp_r_valid() && r_ready, m_cmd || (m_q.size() != 0)};
      checks++;
      if ({req_ready, cmd_valid, r_valid, fifo_rd_ena, busy} !== e) begin
        errors++; $display("FAIL rnd_ctrl_c%0d: got %b want %b", c, {req_ready, cmd_valid, r_valid, fifo_rd_ena, busy}, e);
      end
      checks++;
      if (dut.credit !== 10'(m_credit) || r_err !== exp_r_err()) begin
        errors++; $display("FAIL rnd_credit_c%0d: got credit=%0d err=%b want %0d %b", c, dut.credit, r_err, m_credit, exp_r_err());
      end
      if (m_cmd) begin
        checks++;
        if (cmd_words !== 11'(m_words)) begin errors++; $display("FAIL rnd_words_c%0d: got %0d want %0d", c, cmd_words, m_words); end
      end
      if (e[2]) begin
        checks++;
        if (r_id !== IDW'(m_q[0].id) || r_last !== exp_r_last() || r_data !== f_data[f_rd[9:0]]) begin
          errors++; $display("FAIL rnd_beat_c%0d: got id=%0d last=%b data=%h want %0d %b %h",
                             c, r_id, r_last, r_data, m_q[0].id, exp_r_last(), f_data[f_rd[9:0]]);
        end
      end
      tick();
    end
    flush();
    checks++;
    if (dut.credit !== 10'(DEPTH)) begin errors++; $display("FAIL rnd_credit_end: got %0d want %0d", dut.credit, DEPTH); end
  endtask

  task automatic test_mid_reset();
    issue(7, 1); push_words(8, -1); r_ready = 1; tick(); #1;
    checks++;
    if (r_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: got v=%b busy=%b want 1 1", r_valid, busy); end
    rst = 1; tick(); rst = 0; r_ready = 0; #1;
    checks++;
    if ({busy, r_valid, cmd_valid} !== 3'b0 || dut.credit !== 10'(DEPTH)) begin
      errors++; $display("FAIL midrst_post: got busy/v/cmd=%b credit=%0d want 000 %0d", {busy, r_valid, cmd_valid}, dut.credit, DEPTH);
    end
    tick();
  endtask

  task automatic test_last_check();
    issue(3, 6); push_words(4, 1); r_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({r_valid, r_last, r_err} !== {1'b1, i == 3, LC && (i >= 1)}) begin
        errors++; $display("FAIL last_beat%0d: got v/last/err=%b want %b", i, {r_valid, r_last, r_err}, {1'b1, i == 3, LC && (i >= 1)});
      end
      tick();
    end
    r_ready = 0; #1;
    checks++;
    if (r_err !== LC || busy !== 1'b0) begin errors++; $display("FAIL last_sticky: got err=%b busy=%b want %b 0", r_err, busy, LC); end
    rst = 1; tick(); rst = 0; #1;
    checks++;
    if (r_err !== 1'b0) begin errors++; $display("FAIL last_clear: got %b want 0", r_err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_credit_stall();
    test_queue_full();
    test_backpressure();
    test_simultaneous();
    test_random();
    test_mid_reset();
    test_last_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hbmc_ufifo_rd_sched.md
Name: hbmc_ufifo_rd_sched

Overview:
- Read-side scheduler for the upstream data FIFO, in the system (AXI) clock domain.
- Accepts read-burst requests and issues memory read commands only when FIFO space is guaranteed (credit scheme).
- Drains FIFO words to an AXI-R-style stream with id/last, tracking up to MAX_OUTST bursts in flight.

Parameters:
- DATA_WIDTH, 32, read-side FIFO word width (16/32/64); beat = one FIFO read word.
- FIFO_DEPTH, 512, read-side FIFO capacity in words; initial credit.
- MAX_OUTST, 4, burst descriptor queue depth (power of 2, 2..8).
- ID_WIDTH, 4, transaction id width.

Ports:
- clk  in  1  system clock; FIFO read clock.
- rst  in  1  synchronous active-high reset; FIFO reset asserted by the same event.
- req_valid / req_ready  in / out  1  burst request handshake.
- req_len  in  8  beats-1 (AXI ARLEN).
- req_id  in  ID_WIDTH  burst id.
- cmd_valid / cmd_ready  out / in  1  memory read command handshake.
- cmd_words  out  11  16-bit words to read = (req_len+1)*DATA_WIDTH/16.
- fifo_rd_dout  in  DATA_WIDTH  FWFT FIFO head data.
- fifo_rd_last  in  1  head last flag.
- fifo_rd_empty  in  1  FIFO empty.
- fifo_rd_ena  out  1  FIFO pop.
- r_valid / r_ready  out / in  1  read data handshake.
- r_data  out  DATA_WIDTH  = fifo_rd_dout.
- r_id  out  ID_WIDTH  id of head descriptor.
- r_last  out  1  final beat of burst.
- r_err  out  1  last-flag mismatch (feature only, else 0).
- busy  out  1  any descriptor queued or command pending.

Behaviour:
- Reset: req_ready=0, cmd_valid=0, fifo_rd_ena=0, r_valid=0, r_last=0, r_err=0, busy=0; credit=FIFO_DEPTH; queue empty; beat=0; FSM=IDLE. Mid-burst reset drops all state, no completion.
- Credit: 10-bit counter.
  - Issue subtracts len+1; each pop adds 1.
  - Same-cycle issue and pop apply both (net credit - len + 0).
  - Credit never exceeds FIFO_DEPTH and never goes negative.
- Request FSM:
  - IDLE: req_ready=1 iff credit>=req_len+1 and queue not full. On req_valid&&req_ready: latch len/id, subtract credit, push descriptor {len,id}, go to CMD.
  - CMD: cmd_valid=1 with cmd_words registered. Stay until cmd_ready, then go to IDLE.
  - Latency: req accept to cmd_valid is 1 cycle; back-to-back requests every 2 cycles minimum.
  - Insufficient credit: request stalls (req_ready=0) and is never partially issued.
- Drain (combinational outputs, no bubble):
  - r_valid = queue not empty && !fifo_rd_empty.
  - fifo_rd_ena = r_valid && r_ready.
  - r_last = (beat==head.len).
  - On a handshake: beat++. If r_last, beat=0 and pop descriptor.
  - Descriptor pushed in the same cycle its first data could appear is visible next cycle; data waits in the FIFO.
- busy = (FSM!=IDLE) || queue not empty.
- Queue full (MAX_OUTST descriptors): req_ready=0 even with credit.

Optional Feature:
- Macro HBMC_UFIFO_LAST_CHECK_EN.
- Defined: on each handshake, compare fifo_rd_last with r_last. On mismatch, r_err=1 for that beat (sticky until rst). Beat accounting continues on the descriptor count, ignoring the flag.
- Undefined: fifo_rd_last ignored, r_err tied 0.

Test Plan:
- Single burst: req_len=7, id=3, cmd_ready=1 -> cmd_valid 1 cycle after accept with cmd_words=16. After 8 words are pushed, 8 beats come out with r_id=3 and r_last on beat 8; credit returns to 512.
- Credit stall: issue len=255 twice (credit 0), hold r_ready=0, third req len=0 -> req_ready stays 0. After 1 pop, req_ready=1 and the request is accepted.
- Queue full: MAX_OUTST=4, four len=0 requests with no data -> 5th request gets req_ready=0. One beat drained -> 5th accepted.
- Backpressure: len=3, r_ready toggling 1/0 -> fifo_rd_ena only on r_valid&&r_ready, 4 beats in order, r_last only on the 4th.
- Simultaneous: accept len=15 while popping a beat -> credit changes by exactly -15 that cycle.
- Last check (macro on): fifo_rd_last asserted on beat 2 of len=3 -> r_err=1 from beat 2. Beats 3-4 still delivered, r_last on beat 4.
